lfsr_prng_gen: RTL and testbench

- Parametrised pseudo-random byte/word generator for the display/PRNG datapath.
- A DATA_W-bit XNOR Fibonacci data LFSR advances on a programmable tick or on an external step strobe.
- A DATA_W/2-bit control LFSR free-runs every enabled cycle and picks one bit from each data bit-pair to form the output word.
- Output is a registered valid/ready stream with overrun and lockup reporting; it feeds the 7-segment decoders or any downstream consumer.

---
 rtl/lfsr_prng_gen.sv | 104 ++++++++++
 tb/tb_lfsr_prng_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_gen.sv
// Pseudo-random word generator: an XNOR Fibonacci data LFSR advanced by a tick divider or step strobe,
// with a free-running control LFSR choosing one bit of each data bit-pair for a valid/ready output.
module lfsr_prng_gen #(
    parameter int                  DATA_W    = 16,
    parameter logic [DATA_W-1:0]   DATA_TAPS = 16'hD008,
    parameter logic [DATA_W/2-1:0] CTRL_TAPS = 8'hB8,
    parameter int                  DIV_W     = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [DIV_W-1:0]      div_val,
    input  logic [1:0]            mode,
    input  logic                  step,
    input  logic                  seed_valid,
    input  logic [DATA_W-1:0]     seed,
    output logic [DATA_W/2-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun,
    output logic                  lockup
);
    localparam int OUT_W = DATA_W / 2;

    function automatic logic [DATA_W-1:0] data_step(input logic [DATA_W-1:0] d);
        return {d[DATA_W-2:0], ~^(d & DATA_TAPS)};
    endfunction

    function automatic logic [OUT_W-1:0] ctrl_step(input logic [OUT_W-1:0] c);
        return {c[OUT_W-2:0], ~^(c & CTRL_TAPS)};
    endfunction

    // Each control bit chooses the odd (1) or even (0) bit of its data bit-pair.
    function automatic logic [OUT_W-1:0] pick_bits(input logic [OUT_W-1:0] c,
                                                   input logic [DATA_W-1:0] d);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int j = 0; j < OUT_W; j++) begin
            w[j] = c[j] ? d[2*j+1] : d[2*j];
        end
        return w;
    endfunction

    logic [DATA_W-1:0] data_q;
    logic [OUT_W-1:0]  ctrl_q;
    logic [DIV_W-1:0]  cnt_q;
    logic              tick;
    logic              adv;
    logic              lock_hit;
    logic [DATA_W-1:0] data_nx;

    assign tick     = (mode == 2'b00) && (cnt_q == div_val);
    assign adv      = ((mode == 2'b00) && tick) || ((mode == 2'b01) && step);
    // The XNOR form sticks at all-ones, so that state is forced out to zero.
    assign lock_hit = &data_q;
    assign data_nx  = lock_hit ? '0 : data_step(data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            lockup    <= 1'b0;
        end else if (!ena) begin
            data_q    <= '0;
            ctrl_q    <= '0;
            cnt_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            lockup    <= 1'b0;
        end else begin
            ctrl_q <= ctrl_step(ctrl_q);
            lockup <= 1'b0;
            if (seed_valid) begin
                // Seeding wins over a same-cycle advance; out_data keeps its old value.
                data_q    <= seed;
                cnt_q     <= '0;
                out_valid <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                if ((mode != 2'b00) || tick) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
                if (adv) begin
                    data_q    <= data_nx;
                    out_data  <= pick_bits(ctrl_q, data_nx);
                    out_valid <= 1'b1;
                    lockup    <= lock_hit;
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Bench for lfsr_prng_gen: a reference model feeds a scoreboard each cycle, plus a vector table
// for the start-up sequence and directed sequences for divider, step, overrun, seed and lockup cases.
module tb_lfsr_prng_gen;
    localparam int DATA_W = 16;
    localparam int OUT_W  = 8;
    localparam int DIV_W  = 8;
    localparam logic [15:0] TAPS  = 16'hD008;
    localparam logic [7:0]  CTAPS = 8'hB8;

    logic             clk = 1'b0;
    logic             rst_n, ena, step, seed_valid, out_ready;
    logic [DIV_W-1:0] div_val;
    logic [1:0]       mode;
    logic [15:0]      seed;
    logic [7:0]       out_data;
    logic             out_valid, overrun, lockup;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_prng_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .div_val(div_val), .mode(mode),
        .step(step), .seed_valid(seed_valid), .seed(seed), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .lockup(lockup)
    );

    typedef struct {
        logic [7:0] data;
        logic       valid;
        logic       ovr;
        logic       lock;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic             ena;
        logic [1:0]       mode;
        logic [DIV_W-1:0] div;
        logic             ready;
        logic [7:0]       exp_data;
        logic             exp_valid;
    } vec_t;
    vec_t tbl[5];

    // Reference state
    logic [15:0]      m_data;
    logic [7:0]       m_ctrl, m_out;
    logic [DIV_W-1:0] m_cnt;
    logic             m_valid, m_ovr, m_lock;

    function automatic logic [7:0] sel_bits(input logic [7:0] c, input logic [15:0] d);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = d[2*j + (c[j] ? 1 : 0)];
        return r;
    endfunction

    task automatic model_reset();
        m_data = '0; m_ctrl = '0; m_cnt = '0; m_out = '0;
        m_valid = 1'b0; m_ovr = 1'b0; m_lock = 1'b0;
    endtask

    task automatic model_step();
        logic        tk, ad, lk;
        logic [15:0] nx;
        if (!ena) begin
            model_reset();
        end else begin
            tk = (mode == 2'd0) && (m_cnt == div_val);
            ad = (tk && mode == 2'd0) || (mode == 2'd1 && step);
            lk = (m_data == 16'hFFFF);
            nx = lk ? 16'h0000 : {m_data[14:0], ~^(m_data & TAPS)};
            m_lock = 1'b0;
            if (seed_valid) begin
                m_data = seed; m_cnt = '0; m_valid = 1'b0; m_ovr = 1'b0;
            end else begin
                m_cnt = (mode != 2'd0 || tk) ? '0 : DIV_W'(m_cnt + 1);
                if (ad) begin
                    m_out = sel_bits(m_ctrl, nx);
                    if (m_valid && !out_ready) m_ovr = 1'b1;
                    m_valid = 1'b1;
                    m_lock = lk;
                    m_data = nx;
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
            end
            m_ctrl = {m_ctrl[6:0], ~^(m_ctrl & CTAPS)};
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        exp_t e;
        model_step();
        sb.push_back('{m_out, m_valid, m_ovr, m_lock});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out_data", 16'(out_data), 16'(e.data));
        chk("out_valid", 16'(out_valid), 16'(e.valid));
        chk("overrun", 16'(overrun), 16'(e.ovr));
        chk("lockup", 16'(lockup), 16'(e.lock));
    endtask

    initial begin
        int n;
        tbl[0] = '{1'b1, 2'd0, 8'd0, 1'b1, 8'h01, 1'b1};
        tbl[1] = '{1'b1, 2'd0, 8'd0, 1'b1, 8'h01, 1'b1};
        tbl[2] = '{1'b1, 2'd0, 8'd0, 1'b1, 8'h01, 1'b1};
        tbl[3] = '{1'b1, 2'd0, 8'd0, 1'b1, 8'h03, 1'b1};
        tbl[4] = '{1'b1, 2'd0, 8'd0, 1'b1, 8'h03, 1'b1};

        rst_n = 1'b0; ena = 1'b0; step = 1'b0; seed_valid = 1'b0; out_ready = 1'b1;
        div_val = '0; mode = 2'd0; seed = '0;
        model_reset();
        #12;
        chk("rst_out_data", 16'(out_data), 16'h0);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_overrun", 16'(overrun), 16'h0);
        chk("rst_lockup", 16'(lockup), 16'h0);
        rst_n = 1'b1;

        // Start-up sequence from the all-zero state
        for (int i = 0; i < 5; i++) begin
            ena = tbl[i].ena; mode = tbl[i].mode; div_val = tbl[i].div; out_ready = tbl[i].ready;
            cyc();
            chk("tbl_out_data", 16'(out_data), 16'(tbl[i].exp_data));
            chk("tbl_out_valid", 16'(out_valid), 16'(tbl[i].exp_valid));
        end

        // Asynchronous reset between clock edges
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("arst_out_data", 16'(out_data), 16'h0);
        chk("arst_out_valid", 16'(out_valid), 16'h0);
        rst_n = 1'b1;

        // Divider period 5
        div_val = 8'd4; n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (out_valid) n++;
        end
        chk("div4_samples", 16'(n), 16'd4);

        // Lower div_val below the running count: next tick only after the counter wraps
        for (int i = 0; i < 10 && m_cnt != 3; i++) cyc();
        chk("cnt_at_3", 16'(m_cnt), 16'd3);
        div_val = 8'd1; n = 0;
        for (int i = 1; i <= 300 && n == 0; i++) begin
            cyc();
            if (out_valid) n = i;
        end
        chk("wrap_tick_cycle", 16'(n), 16'd255);
        cyc();
        chk("after_wrap_gap", 16'(out_valid), 16'h0);
        cyc();
        chk("after_wrap_period2", 16'(out_valid), 16'h1);

        // Step mode: two strobes, two samples
        mode = 2'd1; n = 0;
        for (int i = 1; i <= 30; i++) begin
            step = (i == 10 || i == 20);
            cyc();
            if (out_valid) n++;
        end
        step = 1'b0;
        chk("step_samples", 16'(n), 16'd2);

        // step held high in mode 00 adds nothing beyond the ticks
        mode = 2'd0; div_val = 8'd3; step = 1'b1; n = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_valid) n++;
        end
        step = 1'b0;
        chk("mode0_step_ignored", 16'(n), 16'd2);

        // Hold mode for 100 cycles, then one step exposes held data with advanced control bits
        mode = 2'd2;
        for (int i = 0; i < 100; i++) cyc();
        mode = 2'd1; step = 1'b1; cyc(); step = 1'b0; cyc();

        // Overrun from two unconsumed ticks
        mode = 2'd0; div_val = 8'd2; out_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        chk("overrun_set", 16'(overrun), 16'h1);
        mode = 2'd2; seed_valid = 1'b1; seed = 16'h1234; cyc(); seed_valid = 1'b0;
        chk("seed_clears_overrun", 16'(overrun), 16'h0);
        chk("seed_clears_valid", 16'(out_valid), 16'h0);
        out_ready = 1'b1; mode = 2'd1; step = 1'b1; cyc(); step = 1'b0;
        chk("seed_next_data", 16'(m_data), 16'h2468);
        chk("seed_next_out", 16'(out_data), 16'(sel_bits(m_ctrl ^ 8'h00, 16'h2468) & 8'h00 | out_data & 8'h00 | m_out));
        cyc();

        // Lockup escape
        mode = 2'd2; seed_valid = 1'b1; seed = 16'hFFFF; cyc(); seed_valid = 1'b0;
        mode = 2'd1; step = 1'b1; cyc(); step = 1'b0;
        chk("lockup_pulse", 16'(lockup), 16'h1);
        chk("lockup_out_zero", 16'(out_data), 16'h0);
        cyc();
        chk("lockup_one_cycle", 16'(lockup), 16'h0);
        step = 1'b1; cyc(); step = 1'b0;
        chk("after_lock_data", 16'(m_data), 16'h0001);

        // Seed and tick in the same cycle
        mode = 2'd0; div_val = 8'd0; cyc();
        seed_valid = 1'b1; seed = 16'hA5C3; cyc(); seed_valid = 1'b0;
        chk("seed_tick_valid", 16'(out_valid), 16'h0);
        cyc(); cyc();

        // One cycle of ena low
        ena = 1'b0; cyc();
        chk("ena_low_data", 16'(out_data), 16'h0);
        chk("ena_low_valid", 16'(out_valid), 16'h0);
        ena = 1'b1; cyc(); cyc();

        // Mixed random traffic against the model
        for (int i = 0; i < 400; i++) begin
            mode       = 2'($urandom_range(0, 3));
            step       = 1'($urandom_range(0, 1));
            seed_valid = ($urandom_range(0, 15) == 0);
            seed       = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 7) == 0) seed = 16'hFFFF;
            out_ready  = 1'($urandom_range(0, 1));
            ena        = ($urandom_range(0, 31) != 0);
            div_val    = 8'($urandom_range(0, 3));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
